// File: rtl/image_serializer.sv
// Raster-order pixel serializer: captures a flat frame, streams it out one pixel per handshake.
// Optional running pixel checksum enabled by defining SERIALIZER_CHECKSUM_EN.
module image_serializer #(
  parameter int rows       = 4,
  parameter int cols       = 4,
  parameter int data_width = 8,
  localparam int NPIX = rows * cols,
  localparam int RW   = (rows > 1) ? $clog2(rows) : 1,
  localparam int CW   = (cols > 1) ? $clog2(cols) : 1,
  localparam int SW   = data_width + $clog2(NPIX)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [data_width*NPIX-1:0] frame_in,
  input  logic                       frame_valid,
  output logic                       frame_ack,
  output logic                       busy,
  output logic [data_width-1:0]      pix_data,
  output logic                       pix_valid,
  input  logic                       pix_ready,
  output logic [RW-1:0]              pix_row,
  output logic [CW-1:0]              pix_col,
  output logic                       pix_eol,
  output logic                       pix_last,
  output logic [SW-1:0]              frame_sum,
  output logic                       frame_sum_valid
);

  localparam int IW = (NPIX > 1) ? $clog2(NPIX) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_DONE
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [data_width*NPIX-1:0] r_frame;
  logic [IW-1:0]              r_idx;
  logic [RW-1:0]              r_row;
  logic [CW-1:0]              r_col;
  logic                       r_ack;
  logic                       w_cap;
  logic                       w_xfer;
  logic                       w_end;
  logic                       w_send;
  logic [data_width-1:0]      w_pix;

  assign w_send = (r_state == S_SEND);
  assign w_cap  = (r_state == S_IDLE) && frame_valid;
  assign w_xfer = w_send && pix_ready;
  assign w_end  = w_xfer && (r_idx == IW'(NPIX - 1));
  assign w_pix  = r_frame[r_idx*data_width +: data_width];

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state: capture, stream until last transfer, one DONE cycle
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (frame_valid) w_state_nxt = S_SEND;
      S_SEND: if (w_end) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Frame capture and acknowledge pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame <= '0;
      r_ack   <= 1'b0;
    end else begin
      r_ack <= w_cap;
      if (w_cap) r_frame <= frame_in;
    end
  end

  // Pixel index and row/col coordinate counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx <= '0;
      r_row <= '0;
      r_col <= '0;
    end else if (w_cap || w_end) begin
      r_idx <= '0;
      r_row <= '0;
      r_col <= '0;
    end else if (w_xfer) begin
      r_idx <= r_idx + 1'b1;
      if (r_col == CW'(cols - 1)) begin
        r_col <= '0;
        r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign frame_ack = r_ack;
  assign busy      = (r_state != S_IDLE);
  assign pix_valid = w_send;
  assign pix_data  = w_send ? w_pix : '0;
  assign pix_row   = w_send ? r_row : '0;
  assign pix_col   = w_send ? r_col : '0;
  assign pix_eol   = w_send && (r_col == CW'(cols - 1));
  assign pix_last  = w_send && (r_idx == IW'(NPIX - 1));

`ifdef SERIALIZER_CHECKSUM_EN
  logic [SW-1:0] r_sum;

  // Running sum of transferred pixels, restarted on each capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_sum <= '0;
    else if (w_cap)  r_sum <= '0;
    else if (w_xfer) r_sum <= r_sum + SW'(w_pix);
  end

  assign frame_sum       = r_sum;
  assign frame_sum_valid = (r_state == S_DONE);
`else
  assign frame_sum       = '0;
  assign frame_sum_valid = 1'b0;
`endif

endmodule

// File: tb/tb_image_serializer.sv
// Scoreboard bench for image_serializer (4x4, 8-bit pixels).
// Expected pixels come from a raster model of each issued frame.
module tb_image_serializer;

  localparam int R  = 4;
  localparam int C  = 4;
  localparam int DW = 8;
  localparam int N  = R * C;
  localparam int SW = DW + $clog2(N);

  typedef logic [DW-1:0] px_arr_t [N];

  typedef struct {
    logic [DW-1:0] d;
    int            r;
    int            c;
    bit            eol;
    bit            last;
  } pix_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [DW*N-1:0] frame_in;
  logic            frame_valid;
  logic            frame_ack;
  logic            busy;
  logic [DW-1:0]   pix_data;
  logic            pix_valid;
  logic            pix_ready;
  logic [1:0]      pix_row;
  logic [1:0]      pix_col;
  logic            pix_eol;
  logic            pix_last;
  logic [SW-1:0]   frame_sum;
  logic            frame_sum_valid;

  image_serializer #(.rows(R), .cols(C), .data_width(DW)) dut (
    .clk(clk), .rst(rst),
    .frame_in(frame_in), .frame_valid(frame_valid),
    .frame_ack(frame_ack), .busy(busy),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_row(pix_row), .pix_col(pix_col),
    .pix_eol(pix_eol), .pix_last(pix_last),
    .frame_sum(frame_sum), .frame_sum_valid(frame_sum_valid)
  );

  always #5 clk = ~clk;

  pix_t exp_q[$];
  int   sum_q[$];
  int   checks = 0;
  int   errors = 0;
  int   rdy_mode = 0;
  int   acks = 0;
  int   acks_exp = 0;
  int   xfers = 0;
  int   vcyc = 0;
  int   scyc = 0;
  int   cyc = 0;
  int   last_ack = -1;
  bit   hold_mode = 0;
  bit   was_done = 0;
  bit   prev_stall = 0;
  logic [13:0] held;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {34'd0, busy, pix_valid, frame_ack, pix_data, pix_row, pix_col,
            pix_eol, pix_last, frame_sum, frame_sum_valid};
  endfunction

  // Reference model: raster walk over the frame, plus its pixel sum
  task automatic push_exp(input px_arr_t px);
    pix_t e;
    int   s = 0;
    for (int i = 0; i < N; i++) begin
      e.d    = px[i];
      e.r    = i / C;
      e.c    = i % C;
      e.eol  = (i % C) == C - 1;
      e.last = (i == N - 1);
      exp_q.push_back(e);
      s += int'(px[i]);
    end
    sum_q.push_back(s);
    acks_exp++;
  endtask

  task automatic load(input px_arr_t px);
    for (int i = 0; i < N; i++) frame_in[i*DW +: DW] = px[i];
  endtask

  // Ready driver: 0 = always high, 1 = toggling, 2 = random
  initial begin
    pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       pix_ready = ~pix_ready;
        2:       pix_ready = ($urandom % 4) != 0;
        default: pix_ready = 1'b1;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every transfer and checks protocol
  always @(negedge clk) begin
    if (!rst) begin
      was_done   = 0;
      prev_stall = 0;
    end else begin
      cyc++;
      if (frame_ack) begin
        acks++;
        if (hold_mode && last_ack >= 0)
          chk("frame_spacing", cyc - last_ack, N + 2);
        last_ack = cyc;
      end
      if (was_done) chk("done_one_cycle", busy, 0);
      was_done = busy && !pix_valid;
      if (was_done) begin
        chk("send_cycles", vcyc, scyc + N);
        vcyc = 0;
        scyc = 0;
        if (sum_q.size() > 0) begin
`ifdef SERIALIZER_CHECKSUM_EN
          chk("sum_valid", frame_sum_valid, 1);
          chk("frame_sum", frame_sum, sum_q.pop_front());
`else
          void'(sum_q.pop_front());
          chk("sum_tied0", {frame_sum, frame_sum_valid}, 0);
`endif
        end
      end
      if (pix_valid) begin
        vcyc++;
        if (prev_stall)
          chk("stall_stable",
              {pix_data, pix_row, pix_col, pix_eol, pix_last}, held);
        if (pix_ready) begin
          xfers++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pixel: got %0h expected none", pix_data);
          end else begin
            pix_t e;
            e = exp_q.pop_front();
            chk("pixel",
                {pix_data, pix_row, pix_col, pix_eol, pix_last},
                {e.d, 2'(e.r), 2'(e.c), e.eol, e.last});
          end
        end else begin
          scyc++;
        end
        prev_stall = !pix_ready;
        held = {pix_data, pix_row, pix_col, pix_eol, pix_last};
      end else begin
        prev_stall = 0;
      end
    end
  end

  task automatic wait_ack();
    int n = 0;
    while (1) begin
      @(posedge clk);
      #1;
      if (frame_ack) break;
      if (++n > 50) begin
        checks++;
        errors++;
        $display("FAIL ack_timeout: got none expected pulse");
        break;
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy) begin
      @(posedge clk);
      #1;
      if (++n > 300) begin
        checks++;
        errors++;
        $display("FAIL idle_timeout: got busy expected idle");
        break;
      end
    end
  endtask

  // One frame; optionally re-asserts frame_valid with junk data mid-SEND
  task automatic run_frame(input px_arr_t px, input bit inject);
    int a0;
    a0 = acks;
    load(px);
    push_exp(px);
    frame_valid = 1'b1;
    wait_ack();
    chk("first_cycle_valid", pix_valid, 1);
    frame_valid = 1'b0;
    if (inject) begin
      repeat (3) @(posedge clk);
      #1;
      frame_in = '1;
      frame_valid = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      frame_valid = 1'b0;
    end
    wait_idle();
    @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    chk("ack_per_frame", acks - a0, 1);
  endtask

  initial begin
    px_arr_t px;
    rst = 1'b0;
    frame_valid = 1'b0;
    frame_in = '0;
    #12;
    chk("reset_outputs", outs(), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int i = 0; i < N; i++) px[i] = DW'(i + 1);
    rdy_mode = 0;
    run_frame(px, 0);
    rdy_mode = 1;
    run_frame(px, 0);

    rdy_mode = 2;
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < N; i++) px[i] = DW'($urandom);
      if (f == 5) px[N-1] = 8'hFF;
      run_frame(px, 0);
    end

    rdy_mode = 0;
    for (int i = 0; i < N; i++) px[i] = DW'($urandom);
    run_frame(px, 1);

    for (int i = 0; i < N; i++) px[i] = DW'($urandom | 1);
    load(px);
    push_exp(px);
    xfers = 0;
    frame_valid = 1'b1;
    wait_ack();
    frame_valid = 1'b0;
    for (int n = 0; n < 50 && xfers < 5; n++) begin
      @(posedge clk);
      #1;
    end
    chk("xfers_before_reset", xfers, 5);
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset_outputs", outs(), 0);
    exp_q.delete();
    sum_q.delete();
    vcyc = 0;
    scyc = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("no_pixel_after_reset", {busy, pix_valid}, 0);

    for (int i = 0; i < N; i++) px[i] = DW'(i + 1);
    run_frame(px, 0);

    hold_mode = 1;
    last_ack = -1;
    for (int i = 0; i < N; i++) px[i] = DW'($urandom);
    load(px);
    repeat (3) push_exp(px);
    frame_valid = 1'b1;
    repeat (3) wait_ack();
    frame_valid = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("held_queue_drained", exp_q.size(), 0);
    chk("ack_total", acks, acks_exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
